// File: rtl/clock_set_controller_if.sv
// clock_set_controller_if: buttons/tick into the set controller; count clock, mode, busy and blanking out
interface clock_set_controller_if;
  logic tick;
  logic mode_btn;
  logic inc_btn;
  logic cnt_clk;
  logic [1:0] mode;
  logic busy;
  logic blank_min;
  logic blank_hr;
  modport master (output tick, mode_btn, inc_btn, input cnt_clk, mode, busy, blank_min, blank_hr);
  modport slave (input tick, mode_btn, inc_btn, output cnt_clk, mode, busy, blank_min, blank_hr);
endinterface

// File: rtl/clock_set_controller.sv
// clock_set_controller: mode FSM + count pulse engine driving the HH:MM chain clock, with digit blink (ports: clk, R, bus.slave)
module clock_set_controller #(
  parameter int BURST_LEN = 60,
  parameter int BLINK_DIV = 25
) (
  input logic clk,
  input logic R,
  clock_set_controller_if.slave bus
);
  localparam int RW = $clog2(BURST_LEN + 1);
  localparam int DW = $clog2(BLINK_DIV + 1);
  localparam logic [1:0] RUN = 2'd0, SET_MIN = 2'd1, SET_HR = 2'd2;
  logic mode_prev, inc_prev, phase, busy, pending, blink;
  logic [RW-1:0] remaining, load;
  logic [DW-1:0] div;
  logic [1:0] mode;
  logic mode_edge, inc_edge, done, start_pend, start_inc, start, pending_n;
  always_comb begin
    mode_edge = bus.mode_btn & ~mode_prev & ~busy;
    inc_edge = bus.inc_btn & ~inc_prev & ~busy & ~mode_edge;
    done = busy & ~phase & (remaining == '0);
    // a held tick fires in the cycle busy would drop, so back-to-back pulses leave no gap
    start_pend = pending & (done | ~busy);
    start_inc = inc_edge & (mode != RUN);
    start = start_pend | start_inc | (~busy & bus.tick & (mode == RUN));
    load = (start_inc & (mode == SET_HR)) ? RW'(BURST_LEN) : RW'(1);
    pending_n = (mode_edge | start_pend) ? 1'b0 : pending | (busy & bus.tick & (mode == RUN));
  end
  always_ff @(posedge clk) begin
    if (R) begin
      mode_prev <= 1'b1;
      inc_prev <= 1'b1;
      mode <= RUN;
      phase <= 1'b0;
      busy <= 1'b0;
      pending <= 1'b0;
      remaining <= '0;
      div <= '0;
      blink <= 1'b0;
    end else begin
      mode_prev <= bus.mode_btn;
      inc_prev <= bus.inc_btn;
      pending <= pending_n;
      if (mode_edge) mode <= (mode == SET_HR) ? RUN : mode + 2'd1;
      if (start) begin
        remaining <= load;
        phase <= 1'b1;
        busy <= 1'b1;
      end else if (phase) begin
        phase <= 1'b0;
        remaining <= remaining - RW'(1);
      end else if (remaining != '0) begin
        phase <= 1'b1;
      end else begin
        busy <= 1'b0;
      end
      if (mode_edge) begin
        div <= '0;
        blink <= 1'b0;
      end else if (div == DW'(BLINK_DIV - 1)) begin
        div <= '0;
        blink <= ~blink;
      end else begin
        div <= div + DW'(1);
      end
    end
  end
  assign bus.cnt_clk = phase;
  assign bus.mode = mode;
  assign bus.busy = busy;
  assign bus.blank_min = (mode == SET_MIN) & blink;
  assign bus.blank_hr = (mode == SET_HR) & blink;
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: table-driven vectors plus directed blink, minute-set, hour-burst and reset sequences
module tb_clock_set_controller;
  logic clk, R;
  int cmp, errs, falls, f0, bc;
  logic prev_c;
  clock_set_controller_if bus();
  clock_set_controller dut (.clk(clk), .R(R), .bus(bus));
  typedef struct {int t, mb, ib, c, m, b, bm, bh;} vec_t;
  vec_t tbl[25];
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    falls = 0;
    prev_c = 0;
  end
  always @(negedge clk) begin
    if (prev_c & ~bus.cnt_clk) falls = falls + 1;
    prev_c = bus.cnt_clk;
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    cmp++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_all(input string name, input int c, input int m, input int b, input int bm, input int bh);
    chk({name, ".cnt_clk"}, int'(bus.cnt_clk), c);
    chk({name, ".mode"}, int'(bus.mode), m);
    chk({name, ".busy"}, int'(bus.busy), b);
    chk({name, ".blank_min"}, int'(bus.blank_min), bm);
    chk({name, ".blank_hr"}, int'(bus.blank_hr), bh);
  endtask
  initial begin
    cmp = 0;
    errs = 0;
    tbl[0] = '{0,0,0, 0,0,0,0,0};
    tbl[1] = '{1,0,0, 1,0,1,0,0};
    tbl[2] = '{0,0,0, 0,0,1,0,0};
    tbl[3] = '{0,0,0, 0,0,0,0,0};
    tbl[4] = '{1,0,0, 1,0,1,0,0};
    tbl[5] = '{1,0,0, 0,0,1,0,0};
    tbl[6] = '{0,0,0, 1,0,1,0,0};
    tbl[7] = '{0,0,0, 0,0,1,0,0};
    tbl[8] = '{0,0,0, 0,0,0,0,0};
    tbl[9] = '{0,1,0, 0,1,0,0,0};
    tbl[10] = '{0,1,0, 0,1,0,0,0};
    tbl[11] = '{1,0,0, 0,1,0,0,0};
    tbl[12] = '{0,0,1, 1,1,1,0,0};
    tbl[13] = '{0,0,1, 0,1,1,0,0};
    tbl[14] = '{0,0,0, 0,1,0,0,0};
    tbl[15] = '{0,1,1, 0,2,0,0,0};
    tbl[16] = '{0,0,0, 0,2,0,0,0};
    tbl[17] = '{0,1,0, 0,0,0,0,0};
    tbl[18] = '{0,0,0, 0,0,0,0,0};
    tbl[19] = '{0,0,1, 0,0,0,0,0};
    tbl[20] = '{0,0,0, 0,0,0,0,0};
    tbl[21] = '{1,0,0, 1,0,1,0,0};
    tbl[22] = '{0,1,0, 0,0,1,0,0};
    tbl[23] = '{0,1,0, 0,0,0,0,0};
    tbl[24] = '{0,0,0, 0,0,0,0,0};
    R = 1;
    bus.tick = 0;
    bus.mode_btn = 0;
    bus.inc_btn = 0;
    step;
    step;
    chk_all("reset", 0, 0, 0, 0, 0);
    R = 0;
    for (int i = 0; i < 25; i++) begin
      bus.tick = 1'(tbl[i].t);
      bus.mode_btn = 1'(tbl[i].mb);
      bus.inc_btn = 1'(tbl[i].ib);
      step;
      chk_all($sformatf("vec%0d", i), tbl[i].c, tbl[i].m, tbl[i].b, tbl[i].bm, tbl[i].bh);
    end
    bus.tick = 0;
    bus.mode_btn = 0;
    bus.inc_btn = 0;
    bus.mode_btn = 1;
    for (int k = 0; k < 60; k++) begin
      step;
      bus.mode_btn = 0;
      chk($sformatf("blink_min k%0d", k), int'(bus.blank_min), (k / 25) % 2);
      chk($sformatf("blink_hr k%0d", k), int'(bus.blank_hr), 0);
    end
    chk("set_min mode", int'(bus.mode), 1);
    f0 = falls;
    repeat (5) begin
      bus.inc_btn = 1;
      step;
      bus.inc_btn = 0;
      repeat (3) step;
    end
    bus.tick = 1;
    step;
    bus.tick = 0;
    chk("set_min tick busy", int'(bus.busy), 0);
    repeat (3) step;
    chk("set_min pulses", falls - f0, 5);
    bus.mode_btn = 1;
    step;
    bus.mode_btn = 0;
    step;
    chk("set_hr mode", int'(bus.mode), 2);
    f0 = falls;
    bus.inc_btn = 1;
    step;
    bus.inc_btn = 0;
    chk("burst first high", int'(bus.cnt_clk), 1);
    bc = int'(bus.busy);
    for (int k = 1; k <= 130; k++) begin
      bus.inc_btn = (k == 30);
      bus.mode_btn = (k == 30);
      step;
      bc += int'(bus.busy);
    end
    bus.inc_btn = 0;
    bus.mode_btn = 0;
    chk("burst busy cycles", bc, 120);
    chk("burst falls", falls - f0, 60);
    chk("burst mode kept", int'(bus.mode), 2);
    bus.mode_btn = 1;
    step;
    bus.mode_btn = 0;
    step;
    chk("back to run", int'(bus.mode), 0);
    bus.tick = 1;
    step;
    bus.tick = 0;
    chk("pre-reset high", int'(bus.cnt_clk), 1);
    R = 1;
    bus.mode_btn = 1;
    step;
    chk_all("reset mid-pulse", 0, 0, 0, 0, 0);
    step;
    R = 0;
    step;
    step;
    chk("held btn no edge", int'(bus.mode), 0);
    bus.mode_btn = 0;
    step;
    bus.mode_btn = 1;
    step;
    bus.mode_btn = 0;
    chk("repress after reset", int'(bus.mode), 1);
    step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/clock_set_controller.md
# clock_set_controller

Sequencer in front of the HH:MM counter chain. Owns the counter chain's clock input `cnt_clk` and is the only block allowed to advance time. In RUN mode it forwards minute ticks as single count pulses. In the two set modes it turns push-button presses into one pulse (minute set) or a burst of pulses (hour set: 60 pulses advance one hour and leave the minutes unchanged). It also drives the digit-blink blanking signals for the display decoders.

## Interface

Parameters:
- `BURST_LEN`, default 60: pulses per hour-set press.
- `BLINK_DIV`, default 25: clk cycles per blink half-period; must be ≥ 1.

Ports:
- `clk` in 1: system clock; all state updates on its rising edge.
- `R` in 1: one clock; reset is synchronous and active-high.
- `tick` in 1: one-cycle minute enable from the prescaler.
- `mode_btn` in 1: mode button, level, already synchronised and debounced.
- `inc_btn` in 1: increment button, level, already synchronised and debounced.
- `cnt_clk` out 1: clock to the counter chain. The chain advances on each falling transition.
- `mode` out 2: 0 = RUN, 1 = SET_MIN, 2 = SET_HR. Value 3 is never produced.
- `busy` out 1: a count pulse or burst is in flight.
- `blank_min` out 1: blank the M2M1 digits.
- `blank_hr` out 1: blank the H2H1 digits.

## Operation

- **Edge detect.** Each button has a prev register. An edge is `btn & ~prev`.
  - Both prev registers reset to 1, so a button held through reset must be released before it can register.
- **Mode FSM.** A `mode_btn` edge steps RUN → SET_MIN → SET_HR → RUN.
  - The edge is ignored while `busy` = 1. It is not queued.
- **Pulse engine.** Registers: `remaining` (width clog2(BURST_LEN+1)) and `phase`. `cnt_clk` = `phase` (registered).
  - Start: load `remaining` = N, set `phase` = 1, set `busy` = 1.
  - Each cycle: if `phase` = 1, set `phase` = 0 and decrement `remaining`. If `phase` = 0 and `remaining` ≠ 0, set `phase` = 1.
  - When `phase` = 0 and `remaining` = 0, clear `busy`.
- **RUN.**
  - `tick` with the engine idle: start with N = 1.
  - `tick` while `busy`: set the `pending` bit. A pending tick starts N = 1 in the first idle cycle. At most one tick is held; further ticks while pending are dropped.
  - `inc_btn` edges are ignored.
- **SET_MIN.**
  - `inc_btn` edge with the engine idle: start with N = 1.
  - `tick` is dropped.
- **SET_HR.**
  - `inc_btn` edge with the engine idle: start with N = BURST_LEN.
  - `tick` is dropped.
- **In-flight and busy cases.**
  - `inc_btn` edges while `busy` are ignored.
  - A pulse in flight when the mode changes RUN → SET_MIN completes. `pending` is cleared on any mode change.
- **Blink.**
  - Divider counts 0 … BLINK_DIV−1. At wrap, `blink` toggles.
  - Divider and `blink` clear on every mode change, so digits are visible first.
  - `blank_min` = (mode = SET_MIN) & `blink`.
  - `blank_hr` = (mode = SET_HR) & `blink`.
- **Simultaneous events.** `mode_btn` edge and `inc_btn` edge in the same cycle: mode advances and the inc edge is discarded.

## Timing

- **Reset.** `R` sampled at edge k sets, from k onward: `mode` = 0, `cnt_clk` = 0, `busy` = 0, `blank_min` = 0, `blank_hr` = 0, `pending` = 0, `remaining` = 0, divider = 0, `blink` = 0.
  - Reset mid-burst aborts the burst immediately. `cnt_clk` drops to 0, so a reset taken during a high phase produces one falling edge at reset.
- **Single pulse.** `tick` or `inc_btn` edge sampled at edge n:
  - `cnt_clk` = 1 during cycle n…n+1 and 0 from n+1.
  - Counter advance occurs at n+1.
  - `busy` = 1 for cycles n and n+1 and clears at n+2.
- **Burst.** Started at edge n:
  - `cnt_clk` is high after edges n, n+2, …, n+2(BURST_LEN−1).
  - The last falling edge is at n+2·BURST_LEN−1.
  - `busy` clears at n+2·BURST_LEN (n+120 at the default).
- **Mode change.** `mode_btn` edge sampled at edge n: `mode` updates at n. `blank_*` is 0 for at least BLINK_DIV cycles after the change.
- **Pending tick.** A pending tick issues its pulse at the edge where `busy` would clear, so `busy` stays high and there is no idle gap.
- **Sustained rate.** Maximum sustained pulse rate is 1 pulse per 2 clk cycles.

## Test plan

- **Reset.** Assert `R` for 2 cycles while `cnt_clk` = 1 in RUN → all outputs 0 next cycle; `mode_btn` held high through reset gives no mode change until released and re-pressed.
- **RUN ticks.** 3 ticks spaced 10 cycles apart → exactly 3 `cnt_clk` pulses, each high for 1 cycle and starting 1 cycle after its `tick`. Back-to-back ticks on cycles n and n+1 → 2 pulses, the second starting at n+2.
- **Mode walk.** `mode_btn` pressed 3 times → `mode` 1, 2, 0. In SET_MIN with BLINK_DIV = 25, `blank_min` toggles every 25 cycles and `blank_hr` stays 0.
- **Minute set.** In SET_MIN, press `inc_btn` 5 times → exactly 5 pulses. A `tick` during SET_MIN produces no pulse.
- **Hour burst.** In SET_HR, one `inc_btn` edge → exactly 60 falling edges on `cnt_clk` and `busy` high for 120 cycles. A second `inc_btn` and a `mode_btn` press at cycle +30 are both ignored, so `mode` stays 2 and the total stays 60.
- **Simultaneous buttons.** `mode_btn` and `inc_btn` edges in the same cycle in SET_MIN → `mode` = 2 and no pulse.
